// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
// Segment patterns are {a,b,c,d,e,f,g} and active-low, so 0 = segment lit.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // Width needed to count 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to 7-segment pattern decoder.
// Codes 10-15 show A,b,C,d,E,F only when HEX_MODE is nonzero; otherwise blank.
module seg7_decode
    import seg7_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    localparam bit HEX = (HEX_MODE != 0);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = HEX ? SEG_A : SEG_OFF;
            4'hB: seg_o = HEX ? SEG_B : SEG_OFF;
            4'hC: seg_o = HEX ? SEG_C : SEG_OFF;
            4'hD: seg_o = HEX ? SEG_D : SEG_OFF;
            4'hE: seg_o = HEX ? SEG_E : SEG_OFF;
            4'hF: seg_o = HEX ? SEG_F : SEG_OFF;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed N-digit 7-segment scanner: shadow-latched BCD word,
// prescaled digit rotation, per-slot anti-ghost blanking, leading-zero
// suppression. All display outputs are registered (one cycle behind state).
module bcd_7seg_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int CLK_DIV       = 1000,
    parameter int BLANK_CYCLES  = 1,
    parameter int HEX_MODE      = 0,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   bcd,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lz_suppress,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int PW = idx_width(CLK_DIV);

    localparam logic [PW-1:0]         PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]         BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dpsh_q, dpsh_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    wrap;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q, tick_d;

    logic [3:0]              digit_code;
    logic                    digit_dp;
    logic                    digit_lz;
    logic                    tail_zero;
    logic [6:0]              dec_seg;

    // Shadow capture: display only ever reads these, so a load never tears a frame.
    always_comb begin
        bcd_d  = bcd_q;
        dpsh_d = dpsh_q;
        if (load) begin
            bcd_d  = bcd;
            dpsh_d = dp_in;
        end
    end

    // Prescaler and digit index; both park (prescaler at 0) while disabled.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
        if (!en) begin
            presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Select the active digit; scan from the top so tail_zero covers digits i..N-1.
    always_comb begin
        digit_code = bcd_q[3:0];
        digit_dp   = dpsh_q[0];
        digit_lz   = 1'b0;
        tail_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            tail_zero = tail_zero & (bcd_q[4*i +: 4] == 4'h0);
            if (idx_q == IW'(i)) begin
                digit_code = bcd_q[4*i +: 4];
                digit_dp   = dpsh_q[i];
                digit_lz   = tail_zero && (i != 0);
            end
        end
    end

    seg7_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_decode (
        .code_i (digit_code),
        .seg_o  (dec_seg)
    );

    // Next output values: dark while disabled or inside the blank interval.
    always_comb begin
        seg_d  = SEG_OFF;
        dp_d   = 1'b1;
        an_d   = AN_OFF;
        tick_d = wrap;
        if (en && (presc_q >= BLANK_END)) begin
            an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
            seg_d = (lz_suppress && digit_lz) ? SEG_OFF : dec_seg;
            dp_d  = ~digit_dp;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            dpsh_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            an_q    <= AN_OFF;
            tick_q  <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            dpsh_q  <= dpsh_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan: 4 digits, 8-cycle slots, 2 blank cycles.
// Two instances share inputs, one decimal-only and one with hex decode.
module tb_bcd_7seg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic        lz_suppress;

    logic [6:0]  seg0, segh;
    logic        dp0, dph;
    logic [3:0]  an0, anh;
    logic        ft0, fth;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_7seg_scan #(
        .NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2), .HEX_MODE(0), .AN_ACTIVE_LOW(1)
    ) dut_dec (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd(bcd), .dp_in(dp_in),
        .lz_suppress(lz_suppress), .seg(seg0), .dp(dp0), .an(an0), .frame_tick(ft0)
    );

    bcd_7seg_scan #(
        .NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2), .HEX_MODE(1), .AN_ACTIVE_LOW(1)
    ) dut_hex (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .bcd(bcd), .dp_in(dp_in),
        .lz_suppress(lz_suppress), .seg(segh), .dp(dph), .an(anh), .frame_tick(fth)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bcd   = v;
        dp_in = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    // Returns once frame_tick has been seen high (sampled just after the edge).
    task automatic wait_tick(input string name, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            step();
            if (ft0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: frame_tick not seen within 64 cycles", name);
        end
    endtask

    // One full frame after a tick: slot j/8, prescaler j%8; blank for 2 cycles per slot.
    task automatic check_frame(input string name, input logic [27:0] segs,
                               input logic [3:0] dps, input bit hex);
        bit          ok;
        int          act_cnt [4];
        logic [11:0] exp_v, act_v;
        int          d, p;
        for (int k = 0; k < 4; k++) act_cnt[k] = 0;
        wait_tick(name, ok);
        if (!ok) return;
        for (int j = 0; j < 32; j++) begin
            step();
            d = j / 8;
            p = j % 8;
            if (p < 2) exp_v = {4'b1111, 7'b1111111, 1'b1};
            else       exp_v = {~(4'b0001 << d), segs[d*7 +: 7], ~dps[d]};
            act_v = hex ? {anh, segh, dph} : {an0, seg0, dp0};
            checks++;
            if (act_v !== exp_v || (hex ? fth : ft0) !== (j == 31)) begin
                failures++;
                $display("FAIL %s cyc=%0d an/seg/dp got=%b exp=%b tick got=%b exp=%b",
                         name, j, act_v, exp_v, hex ? fth : ft0, (j == 31));
            end
            if ((hex ? anh : an0) != 4'b1111) act_cnt[d]++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (act_cnt[k] !== 6) begin
                failures++;
                $display("FAIL %s digit%0d active cycles got=%0d exp=6", name, k, act_cnt[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; load = 1'b0; bcd = '0; dp_in = '0; lz_suppress = 1'b0;
        repeat (3) step();
        checks++;
        if ({seg0, dp0, an0, ft0} !== {7'b1111111, 1'b1, 4'b1111, 1'b0} ||
            {segh, dph, anh, fth} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
            failures++;
            $display("FAIL reset got=%b/%b exp=%b", {seg0, dp0, an0, ft0}, {segh, dph, anh, fth},
                     {7'b1111111, 1'b1, 4'b1111, 1'b0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_scan();
        do_load(16'h1234, 4'b0100);
        check_frame("scan_1234", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b0100, 1'b0);
    endtask

    task automatic test_lz();
        lz_suppress = 1'b1;
        do_load(16'h0005, 4'b0000);
        check_frame("lz_0005", {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}, 4'b0000, 1'b0);
        do_load(16'h0000, 4'b0000);
        check_frame("lz_0000", {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b0000, 1'b0);
        do_load(16'h0105, 4'b0000);
        check_frame("lz_0105", {7'b1111111, 7'b1001111, 7'b0000001, 7'b0100100}, 4'b0000, 1'b0);
        lz_suppress = 1'b0;
    endtask

    task automatic test_hex();
        do_load(16'hAB0F, 4'b0001);
        check_frame("hex_off", {7'b1111111, 7'b1111111, 7'b0000001, 7'b1111111}, 4'b0001, 1'b0);
        check_frame("hex_on",  {7'b0001000, 7'b1100000, 7'b0000001, 7'b0111000}, 4'b0001, 1'b1);
    endtask

    task automatic test_enable();
        bit ok;
        do_load(16'h1234, 4'b0100);
        wait_tick("enable", ok);
        if (!ok) return;
        repeat (20) step();          // state now index 2, prescaler 4
        checks++;
        if ({an0, seg0, dp0} !== {4'b1011, 7'b0010010, 1'b0}) begin
            failures++;
            $display("FAIL en_before got=%b exp=%b", {an0, seg0, dp0}, {4'b1011, 7'b0010010, 1'b0});
        end
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({an0, seg0, dp0, ft0} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL en_low cyc=%0d got=%b exp=%b", k, {an0, seg0, dp0, ft0},
                         {4'b1111, 7'b1111111, 1'b1, 1'b0});
            end
        end
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (an0 !== 4'b1111 || seg0 !== 7'b1111111) begin
                failures++;
                $display("FAIL en_resume_blank cyc=%0d an got=%b exp=1111 seg got=%b", k, an0, seg0);
            end
        end
        step();
        checks++;
        if ({an0, seg0, dp0} !== {4'b1011, 7'b0010010, 1'b0}) begin
            failures++;
            $display("FAIL en_resume got=%b exp=%b", {an0, seg0, dp0}, {4'b1011, 7'b0010010, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_load(16'h1234, 4'b0000);
        wait_tick("b2b", ok);
        if (!ok) return;
        repeat (3) step();           // state index 0, prescaler 3
        bcd = 16'h5678; dp_in = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (seg0 !== 7'b1001100) begin
            failures++;
            $display("FAIL load_old seg got=%b exp=1001100", seg0);
        end
        step();
        checks++;
        if (seg0 !== 7'b0000000) begin
            failures++;
            $display("FAIL load_new seg got=%b exp=0000000", seg0);
        end
        repeat (2) step();           // state index 0, prescaler 7: next edge changes slot
        bcd = 16'h5698; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if ({an0, seg0} !== {4'b1110, 7'b0000000}) begin
            failures++;
            $display("FAIL boundary_last got=%b exp=%b", {an0, seg0}, {4'b1110, 7'b0000000});
        end
        repeat (3) step();
        checks++;
        if ({an0, seg0} !== {4'b1101, 7'b0000100}) begin
            failures++;
            $display("FAIL boundary_new got=%b exp=%b", {an0, seg0}, {4'b1101, 7'b0000100});
        end
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({seg0, dp0, an0, ft0} !== {7'b1111111, 1'b1, 4'b1111, 1'b0}) begin
            failures++;
            $display("FAIL midreset got=%b exp=%b", {seg0, dp0, an0, ft0},
                     {7'b1111111, 1'b1, 4'b1111, 1'b0});
        end
        check_frame("post_reset_shadow",
                    {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b0000, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_lz();
        test_hex();
        test_enable();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
